pipe_scroller: RTL and testbench
================================

// Module: pipe_scroller
// PURPOSE
//  Owns the obstacle field for the game. Each frame it scrolls every live pipe left,
//  retires pipes that reach the left screen edge and spawns new pipes at the right edge
//  with an LFSR-chosen gap position. It also pulses once per pipe the bird clears. Its
//  packed per-slot outputs drive the pipe renderer instances directly: x_left_edge,
//  y_bottom_pipe_top and y_gap_height. An all-zero y pair means the slot is empty.
// PARAMETERS
//  NUM_PIPES      3        pipe slots (renderer instances)
//  SCREEN_WIDTH   640      spawn x coordinate for a new pipe
//  PIPE_WIDTH     70       pipe width in px, used for the score crossing
//  PIPE_SPACING   220      px scrolled between spawns
//  SCROLL_STEP    2        px moved per frame_tick; must be >=1
//  GAP_HEIGHT     120      y_gap_height given to every spawned pipe
//  GAP_Y_MIN      60       y_bottom_pipe_top = GAP_Y_MIN + lfsr[6:0]; must be >=1
//  BIRD_X         160      x of bird column, used for scoring
//  LFSR_SEED      16'hACE1 LFSR reset value; must be nonzero
// PORTS
//  clk               in   1             system clock
//  resetn            in   1             async active-low reset
//  start             in   1             1-cycle pulse: clear field and begin a game
//  collision         in   1             level; freezes the field while RUN is active
//  frame_tick        in   1             1-cycle pulse per frame, at start of vblank
//  pipe_x_left_edge  out  32*NUM_PIPES  slot i at [32i+31:32i]; zero-extended 10b x
//  pipe_y_bottom_top out  32*NUM_PIPES  slot i y_bottom_pipe_top; 0 = empty slot
//  pipe_y_gap_height out  32*NUM_PIPES  slot i y_gap_height; 0 = empty slot
//  running           out  1             1 in RUN, WAIT_TICK and SCROLL/SPAWN states
//  busy              out  1             1 while SCROLL or SPAWN is in progress
//  score_pulse       out  1             1-cycle pulse when a pipe passes BIRD_X
// BEHAVIOUR
//  - Reset (async, resetn=0): all pipe outputs are 0, running=0, busy=0 and
//    score_pulse=0. The LFSR loads LFSR_SEED, spawn_ctr=0 and the FSM enters IDLE.
//    Reset has effect mid-SCROLL/SPAWN with no partial update surviving.
//  - FSM: IDLE -> (start) CLEAR -> WAIT_TICK -> (frame_tick) SCROLL -> SPAWN -> WAIT_TICK.
//    From WAIT_TICK, collision goes to FROZEN. FROZEN and IDLE leave only on start.
//    In any state, start goes to CLEAR on the next edge, which preempts a frame in progress.
//  - CLEAR (1 cycle): all slots are zeroed and spawn_ctr=0. The LFSR is NOT reseeded.
//  - SCROLL: one slot per cycle, i=0..NUM_PIPES-1, so it takes NUM_PIPES cycles.
//    Empty slots are skipped. For a live slot with 10-bit x:
//    - if x < SCROLL_STEP, the slot is zeroed (retired);
//    - else x <= x - SCROLL_STEP, and score_pulse=1 that cycle if
//      (x+PIPE_WIDTH) >= BIRD_X and (x-SCROLL_STEP+PIPE_WIDTH) < BIRD_X.
//    spawn_ctr <= sat0(spawn_ctr - SCROLL_STEP) in the first SCROLL cycle.
//  - SPAWN (1 cycle): if spawn_ctr==0, the lowest-index empty slot gets
//    x=SCREEN_WIDTH, y_bottom_pipe_top=GAP_Y_MIN+lfsr[6:0] and y_gap_height=GAP_HEIGHT.
//    The LFSR then advances one step and spawn_ctr reloads PIPE_SPACING.
//    If no slot is empty, nothing is written and the LFSR holds, but spawn_ctr still reloads.
//  - A newly spawned pipe is not scrolled in its spawn frame.
//  - LFSR: 16-bit Galois right shift: l <= (l>>1) ^ (l[0] ? 16'hB400 : 0). It advances only on spawn.
//  - A frame_tick that arrives while busy=1, or outside WAIT_TICK, is ignored without queueing.
//  - collision is sampled only in WAIT_TICK, so a frame already started always completes.
//  - Outputs are registered and change only in CLEAR/SCROLL/SPAWN. The renderer sees
//    updates during vblank because the frame latency is NUM_PIPES+1 cycles after frame_tick.
// TESTING
//  1 Reset asserted mid-SCROLL -> on the same edge all outputs 0 and running=0; after
//    release the first spawn again uses lfsr 16'hACE1.
//  2 Start, then 1 tick -> 4 cycles later slot0 = (640, 157, 120), slots 1-2 are 0, the
//    LFSR is 16'hE270 and spawn_ctr=220.
//  3 110 further ticks -> slot0 x=420 and slot1 x=640, with its y taken from LFSR 16'hE270 (y=60+0x70=172).
//  4 Tick 277 after start -> exactly one score_pulse, during the SCROLL cycle of slot0
//    (x 90->88). Tick 321 -> slot0 x=0; tick 322 -> slot0 all 0.
//  5 Collision=1 in WAIT_TICK, then 5 ticks -> outputs frozen and running=0. A start pulse
//    then clears all slots, and the next tick spawns with the continued LFSR value.
//  6 NUM_PIPES=1 and PIPE_SPACING=100, 50 ticks after the first spawn -> no second
//    spawn, slot0 unchanged except scroll, the LFSR holds and spawn_ctr=100.
//    A frame_tick while busy=1 -> no extra scroll.

Source files
------------

// File: rtl/pipe_scroller.sv
// pipe_scroller: obstacle field owner for the game.
// Once per frame the live pipes are scrolled left one slot per cycle, pipes that
// reach the left edge are retired, and a new pipe may be spawned at the right edge
// with an LFSR-chosen gap. The bird is credited with a score pulse each time a
// pipe's trailing edge slides past the bird column. All outputs are registered and
// only move during CLEAR/SCROLL/SPAWN, so the renderer sees a stable field outside
// the short per-frame update burst.
module pipe_scroller #(
    parameter int unsigned NUM_PIPES    = 3,
    parameter int unsigned SCREEN_WIDTH = 640,
    parameter int unsigned PIPE_WIDTH   = 70,
    parameter int unsigned PIPE_SPACING = 220,
    parameter int unsigned SCROLL_STEP  = 2,
    parameter int unsigned GAP_HEIGHT   = 120,
    parameter int unsigned GAP_Y_MIN    = 60,
    parameter int unsigned BIRD_X       = 160,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic                     collision,
    input  logic                     frame_tick,
    output logic [32*NUM_PIPES-1:0]  pipe_x_left_edge,
    output logic [32*NUM_PIPES-1:0]  pipe_y_bottom_top,
    output logic [32*NUM_PIPES-1:0]  pipe_y_gap_height,
    output logic                     running,
    output logic                     busy,
    output logic                     score_pulse
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int unsigned IDX_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIPES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_SCROLL = 3'd3;
    localparam logic [2:0] S_SPAWN  = 3'd4;
    localparam logic [2:0] S_FROZEN = 3'd5;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [15:0]      spawn_ctr_q, spawn_ctr_d;
    logic             score_q, score_d;

    logic [9:0] x_q    [NUM_PIPES];
    logic [9:0] x_d    [NUM_PIPES];
    logic [9:0] ybot_q [NUM_PIPES];
    logic [9:0] ybot_d [NUM_PIPES];
    logic [9:0] gap_q  [NUM_PIPES];
    logic [9:0] gap_d  [NUM_PIPES];

    // ------------------------------------------------------------------
    // Derived per-slot signals
    // ------------------------------------------------------------------
    logic [NUM_PIPES-1:0] live;

    logic [9:0]       cur_x;
    logic             cur_live;
    logic [9:0]       cur_x_next;
    logic             cur_retire;
    logic             cur_score_hit;

    logic             free_found;
    logic [IDX_W-1:0] free_idx;

    logic [15:0]      lfsr_step;
    logic [15:0]      ctr_sat;
    logic [9:0]       spawn_ybot;

    // A slot is empty exactly when both y fields are zero.
    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_live
        assign live[g] = (ybot_q[g] != 10'd0) || (gap_q[g] != 10'd0);
    end

    // Select the slot currently being scrolled.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        cur_x    = 10'd0;
        cur_live = 1'b0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_x    = x_q[i];
                cur_live = live[i];
            end
        end
    end

    // Scroll arithmetic for the selected slot; widened to 12 bits so the
    // pipe-width sums cannot wrap.
    assign cur_retire    = {2'b00, cur_x} < 12'(SCROLL_STEP);
    assign cur_x_next    = cur_x - 10'(SCROLL_STEP);
    assign cur_score_hit = (({2'b00, cur_x}      + 12'(PIPE_WIDTH)) >= 12'(BIRD_X)) &&
                           (({2'b00, cur_x_next} + 12'(PIPE_WIDTH)) <  12'(BIRD_X));

    // Find the lowest-index empty slot for a spawn.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (!free_found && !live[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Galois LFSR step, saturating spawn countdown and spawn gap position.
    assign lfsr_step  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    assign ctr_sat    = (spawn_ctr_q > 16'(SCROLL_STEP)) ? (spawn_ctr_q - 16'(SCROLL_STEP))
                                                         : 16'd0;
    assign spawn_ybot = 10'(GAP_Y_MIN) + {3'b000, lfsr_q[6:0]};

    // ------------------------------------------------------------------
    // Next-state logic: FSM plus slot/LFSR/counter updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lfsr_d      = lfsr_q;
        spawn_ctr_d = spawn_ctr_q;
        score_d     = 1'b0;
        x_d         = x_q;
        ybot_d      = ybot_q;
        gap_d       = gap_q;

        if (start) begin
            // start preempts whatever is in progress; no partial frame update
            // is committed because CLEAR wipes the field next anyway.
            state_d = S_CLEAR;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        x_d[i]    = 10'd0;
                        ybot_d[i] = 10'd0;
                        gap_d[i]  = 10'd0;
                    end
                    spawn_ctr_d = 16'd0;
                    idx_d       = '0;
                    state_d     = S_WAIT;
                end

                S_WAIT: begin
                    // collision is only looked at here, so a started frame
                    // always runs to completion.
                    if (collision) begin
                        state_d = S_FROZEN;
                    end else if (frame_tick) begin
                        state_d = S_SCROLL;
                        idx_d   = '0;
                    end
                end

                S_SCROLL: begin
                    if (idx_q == '0) begin
                        spawn_ctr_d = ctr_sat;
                    end
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        if ((idx_q == IDX_W'(i)) && cur_live) begin
                            if (cur_retire) begin
                                x_d[i]    = 10'd0;
                                ybot_d[i] = 10'd0;
                                gap_d[i]  = 10'd0;
                            end else begin
                                x_d[i]  = cur_x_next;
                                score_d = cur_score_hit;
                            end
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = S_SPAWN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end

                S_SPAWN: begin
                    if (spawn_ctr_q == 16'd0) begin
                        if (free_found) begin
                            for (int i = 0; i < NUM_PIPES; i++) begin
                                if (free_idx == IDX_W'(i)) begin
                                    x_d[i]    = 10'(SCREEN_WIDTH);
                                    ybot_d[i] = spawn_ybot;
                                    gap_d[i]  = 10'(GAP_HEIGHT);
                                end
                            end
                            // The LFSR only advances when a pipe is actually placed.
                            lfsr_d = lfsr_step;
                        end
                        spawn_ctr_d = 16'(PIPE_SPACING);
                    end
                    state_d = S_WAIT;
                end

                S_IDLE, S_FROZEN: begin
                    // Held until the next start.
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // Register all state; async reset returns the whole field to empty.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!resetn) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            lfsr_q      <= LFSR_SEED;
            spawn_ctr_q <= 16'd0;
            score_q     <= 1'b0;
            // NOTE: the slot arrays are a handful of flops driving outputs, not a
            // RAM, so they are reset explicitly to present an empty field.
            for (int i = 0; i < NUM_PIPES; i++) begin
                x_q[i]    <= 10'd0;
                ybot_q[i] <= 10'd0;
                gap_q[i]  <= 10'd0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lfsr_q      <= lfsr_d;
            spawn_ctr_q <= spawn_ctr_d;
            score_q     <= score_d;
            x_q         <= x_d;
            ybot_q      <= ybot_d;
            gap_q       <= gap_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_out
        assign pipe_x_left_edge[32*g +: 32]  = {22'd0, x_q[g]};
        assign pipe_y_bottom_top[32*g +: 32] = {22'd0, ybot_q[g]};
        assign pipe_y_gap_height[32*g +: 32] = {22'd0, gap_q[g]};
    end

    assign running     = (state_q == S_WAIT) || (state_q == S_SCROLL) || (state_q == S_SPAWN);
    assign busy        = (state_q == S_SCROLL) || (state_q == S_SPAWN);
    assign score_pulse = score_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed testbench for pipe_scroller: a 3-slot instance covers reset, spawn,
// scroll, scoring, retirement and freeze; a 1-slot instance with a short spacing
// covers the full-field spawn and ticks that arrive while busy.
module tb_pipe_scroller;

    localparam int NP  = 3;
    localparam int NP1 = 1;

    logic clk = 1'b0;
    logic resetn;

    logic start, collision, frame_tick;
    logic [32*NP-1:0] pipe_x, pipe_yb, pipe_gh;
    logic running, busy, score_pulse;

    logic start1, collision1, frame_tick1;
    logic [32*NP1-1:0] pipe_x1, pipe_yb1, pipe_gh1;
    logic running1, busy1, score_pulse1;

    int n_pass  = 0;
    int n_total = 0;
    int last_pulses;
    int score_total;
    logic [31:0] held;

    always #5 clk = ~clk;

    pipe_scroller dut (
        .clk               (clk),
        .resetn            (resetn),
        .start             (start),
        .collision         (collision),
        .frame_tick        (frame_tick),
        .pipe_x_left_edge  (pipe_x),
        .pipe_y_bottom_top (pipe_yb),
        .pipe_y_gap_height (pipe_gh),
        .running           (running),
        .busy              (busy),
        .score_pulse       (score_pulse)
    );

    pipe_scroller #(.NUM_PIPES(1), .PIPE_SPACING(100)) dut1 (
        .clk               (clk),
        .resetn            (resetn),
        .start             (start1),
        .collision         (collision1),
        .frame_tick        (frame_tick1),
        .pipe_x_left_edge  (pipe_x1),
        .pipe_y_bottom_top (pipe_yb1),
        .pipe_y_gap_height (pipe_gh1),
        .running           (running1),
        .busy              (busy1),
        .score_pulse       (score_pulse1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h (%0d) expected 0x%0h (%0d)", tag, obs, obs, exp, exp);
    endtask

    function automatic logic [31:0] sx(int i);
        return pipe_x[32*i +: 32];
    endfunction
    function automatic logic [31:0] syb(int i);
        return pipe_yb[32*i +: 32];
    endfunction
    function automatic logic [31:0] sgh(int i);
        return pipe_gh[32*i +: 32];
    endfunction

    // One frame on the 3-slot instance: tick for one edge, then wait out the
    // NUM_PIPES+1 update cycles, counting score pulses seen on the way.
    task automatic frame();
        int p;
        p = 0;
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        if (score_pulse) p++;
        repeat (4) begin
            @(negedge clk);
            if (score_pulse) p++;
        end
        last_pulses = p;
        score_total += p;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) frame();
    endtask

    task automatic frame1();
        @(negedge clk) frame_tick1 = 1'b1;
        @(negedge clk) frame_tick1 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_start1();
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        start = 1'b0; collision = 1'b0; frame_tick = 1'b0;
        start1 = 1'b0; collision1 = 1'b0; frame_tick1 = 1'b0;
        score_total = 0;
        last_pulses = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_x0", sx(0), 32'd0);
        check("rst_yb0", syb(0), 32'd0);
        check("rst_running", {31'd0, running}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_score", {31'd0, score_pulse}, 32'd0);
        check("rst_lfsr", {16'd0, dut.lfsr_q}, 32'h0000ACE1);
        check("rst_ctr", {16'd0, dut.spawn_ctr_q}, 32'd0);
        resetn = 1'b1;

        // Reset asserted in the middle of a SCROLL
        pulse_start();
        frame();
        frame();
        check("pre_rst_x0", sx(0), 32'd638);
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        check("mid_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_x0", sx(0), 32'd0);
        check("mid_rst_yb0", syb(0), 32'd0);
        check("mid_rst_gh0", sgh(0), 32'd0);
        check("mid_rst_running", {31'd0, running}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_lfsr", {16'd0, dut.lfsr_q}, 32'h0000ACE1);
        @(negedge clk) resetn = 1'b1;

        // Start and first spawn
        pulse_start();
        check("start_running", {31'd0, running}, 32'd0);
        @(negedge clk);
        check("wait_running", {31'd0, running}, 32'd1);
        score_total = 0;
        frame();
        check("t1_x0", sx(0), 32'd640);
        check("t1_yb0", syb(0), 32'd157);
        check("t1_gh0", sgh(0), 32'd120);
        check("t1_x1", sx(1), 32'd0);
        check("t1_yb1", syb(1), 32'd0);
        check("t1_gh2", sgh(2), 32'd0);
        check("t1_lfsr", {16'd0, dut.lfsr_q}, 32'h0000E270);
        check("t1_ctr", {16'd0, dut.spawn_ctr_q}, 32'd220);
        check("t1_busy", {31'd0, busy}, 32'd0);

        // Second spawn after PIPE_SPACING px of scrolling
        frames(110);
        check("t111_x0", sx(0), 32'd420);
        check("t111_x1", sx(1), 32'd640);
        check("t111_yb1", syb(1), 32'd172);
        check("t111_gh1", sgh(1), 32'd120);
        check("t111_yb2", syb(2), 32'd0);
        check("t111_lfsr", {16'd0, dut.lfsr_q}, 32'h00007138);

        // Scoring and retirement of slot 0
        frames(165);
        check("t276_x0", sx(0), 32'd90);
        check("t276_score_none", score_total, 32'd0);
        frame();
        check("t277_x0", sx(0), 32'd88);
        check("t277_pulses", last_pulses, 32'd1);
        frames(44);
        check("t321_x0", sx(0), 32'd0);
        check("t321_yb0", syb(0), 32'd157);
        frame();
        check("t322_x0", sx(0), 32'd0);
        check("t322_yb0", syb(0), 32'd0);
        check("t322_gh0", sgh(0), 32'd0);
        check("t322_score_total", score_total, 32'd1);
        check("t322_x2", sx(2), 32'd438);
        check("t322_yb2", syb(2), 32'd116);
        check("t322_lfsr", {16'd0, dut.lfsr_q}, 32'h0000389C);

        // Collision freezes the field
        @(negedge clk) collision = 1'b1;
        @(negedge clk) collision = 1'b0;
        check("frz_running", {31'd0, running}, 32'd0);
        held = sx(1);
        frames(5);
        check("frz_x1", sx(1), held);
        check("frz_x2", sx(2), 32'd438);
        check("frz_running2", {31'd0, running}, 32'd0);
        check("frz_busy", {31'd0, busy}, 32'd0);
        pulse_start();
        @(negedge clk);
        check("clr_x1", sx(1), 32'd0);
        check("clr_yb2", syb(2), 32'd0);
        check("clr_running", {31'd0, running}, 32'd1);
        check("clr_lfsr", {16'd0, dut.lfsr_q}, 32'h0000389C);
        frame();
        check("resp_x0", sx(0), 32'd640);
        check("resp_yb0", syb(0), 32'd88);
        check("resp_lfsr", {16'd0, dut.lfsr_q}, 32'h00001C4E);

        // Single-slot instance: full field and busy ticks
        pulse_start1();
        frame1();
        check("n1_x0", pipe_x1[31:0], 32'd640);
        check("n1_yb0", pipe_yb1[31:0], 32'd157);
        check("n1_ctr", {16'd0, dut1.spawn_ctr_q}, 32'd100);
        for (int k = 0; k < 50; k++) frame1();
        check("n1_t50_x0", pipe_x1[31:0], 32'd540);
        check("n1_t50_yb0", pipe_yb1[31:0], 32'd157);
        check("n1_t50_lfsr", {16'd0, dut1.lfsr_q}, 32'h0000E270);
        check("n1_t50_ctr", {16'd0, dut1.spawn_ctr_q}, 32'd100);
        @(negedge clk) frame_tick1 = 1'b1;
        @(negedge clk);
        check("n1_busy", {31'd0, busy1}, 32'd1);
        @(negedge clk) frame_tick1 = 1'b0;
        repeat (4) @(negedge clk);
        check("n1_busy_tick_x0", pipe_x1[31:0], 32'd538);
        check("n1_busy_tick_ctr", {16'd0, dut1.spawn_ctr_q}, 32'd98);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
